// File: rtl/msrv32_wr_en_generator.sv
// msrv32_wr_en_generator
// Write-back stage write-enable qualifier for the msrv32 two-stage RV32I core.
// The integer register file and CSR write requests are gated by the pipeline
// flush so a squashed instruction never updates architectural state.
// flush_q_out carries flush_in delayed by one clock.
// Optional build macro: MSRV32_WR_EN_STATS_EN adds saturating debug counters
// for committed integer writes, committed CSR writes and squashed requests.
// Without it the counter ports read constant zero and no counter flops exist.
module msrv32_wr_en_generator #(
    parameter int CNT_W = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             flush_in,
    input  logic             rf_wr_en_reg_in,
    input  logic             csr_wr_en_reg_in,
    output logic             wr_en_integer_file_out,
    output logic             wr_en_csr_file_out,
    output logic             flush_q_out,
    output logic [CNT_W-1:0] rf_wr_cnt_out,
    output logic [CNT_W-1:0] csr_wr_cnt_out,
    output logic [CNT_W-1:0] squash_cnt_out
);

    logic flush_d;
    logic flush_q;

    // Flush overrides both requests; the AND form keeps an unknown flush from
    // asserting an enable. Reset deliberately does not gate these paths.
    assign wr_en_integer_file_out = rf_wr_en_reg_in  & ~flush_in;
    assign wr_en_csr_file_out     = csr_wr_en_reg_in & ~flush_in;

    assign flush_d     = flush_in;
    assign flush_q_out = flush_q;

    // One-cycle delayed copy of the flush, cleared while reset is low.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_d;
        end
    end

`ifdef MSRV32_WR_EN_STATS_EN
    logic [CNT_W-1:0] rf_cnt_q,     rf_cnt_d;
    logic [CNT_W-1:0] csr_cnt_q,    csr_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             squash_ev;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        if (en && (cnt != {CNT_W{1'b1}})) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    // A squashed cycle counts once even when both requests were pending.
    assign squash_ev = flush_in & (rf_wr_en_reg_in | csr_wr_en_reg_in);

    // Next-state values for the three statistics counters.
    always_comb begin
        rf_cnt_d     = sat_inc(rf_cnt_q,     wr_en_integer_file_out);
        csr_cnt_d    = sat_inc(csr_cnt_q,    wr_en_csr_file_out);
        squash_cnt_d = sat_inc(squash_cnt_q, squash_ev);
    end

    // Counter registers; reset wins over any pending increment.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            rf_cnt_q     <= '0;
            csr_cnt_q    <= '0;
            squash_cnt_q <= '0;
        end else begin
            rf_cnt_q     <= rf_cnt_d;
            csr_cnt_q    <= csr_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign rf_wr_cnt_out  = rf_cnt_q;
    assign csr_wr_cnt_out = csr_cnt_q;
    assign squash_cnt_out = squash_cnt_q;
`else
    assign rf_wr_cnt_out  = '0;
    assign csr_wr_cnt_out = '0;
    assign squash_cnt_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_wr_en_generator.sv
// Directed bench for msrv32_wr_en_generator using an expected-value queue.
// Counter expectations follow MSRV32_WR_EN_STATS_EN: real counts when it is
// defined, constant zero otherwise.
module tb_msrv32_wr_en_generator;

    localparam int CNT_W = 4;
`ifdef MSRV32_WR_EN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             rf_req;
    logic             csr_req;
    logic             int_en;
    logic             csr_en;
    logic             flush_q;
    logic [CNT_W-1:0] rf_cnt;
    logic [CNT_W-1:0] csr_cnt;
    logic [CNT_W-1:0] squash_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    msrv32_wr_en_generator #(.CNT_W(CNT_W)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_in   (rst_n),
        .flush_in               (flush),
        .rf_wr_en_reg_in        (rf_req),
        .csr_wr_en_reg_in       (csr_req),
        .wr_en_integer_file_out (int_en),
        .wr_en_csr_file_out     (csr_en),
        .flush_q_out            (flush_q),
        .rf_wr_cnt_out          (rf_cnt),
        .csr_wr_cnt_out         (csr_cnt),
        .squash_cnt_out         (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty observed %0d with no expectation", obs);
            $error("scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $display("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
                $error("%s observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] exp,
                              input logic [31:0] obs);
        push_exp(tag, exp);
        pop_chk(obs);
    endtask

    // Sample #1 after the active edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_counters(input string tag, input int rf_e, input int csr_e,
                                input int sq_e);
        expect_now({tag, "_rf_cnt"},     STATS ? 32'(rf_e)  : 32'd0, 32'(rf_cnt));
        expect_now({tag, "_csr_cnt"},    STATS ? 32'(csr_e) : 32'd0, 32'(csr_cnt));
        expect_now({tag, "_squash_cnt"}, STATS ? 32'(sq_e)  : 32'd0, 32'(squash_cnt));
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b1;
        rf_req  = 1'b0;
        csr_req = 1'b0;

        // Reset held for two edges with flush high.
        tick(2);
        expect_now("rst_flush_q", 32'd0, 32'(flush_q));
        chk_counters("rst", 0, 0, 0);

        // Combinational gating, still in reset: reset must not gate enables.
        flush = 1'b0; rf_req = 1'b1; csr_req = 1'b0; #1;
        expect_now("rf_only_int", 32'd1, 32'(int_en));
        expect_now("rf_only_csr", 32'd0, 32'(csr_en));
        rf_req = 1'b0; csr_req = 1'b1; #1;
        expect_now("csr_only_int", 32'd0, 32'(int_en));
        expect_now("csr_only_csr", 32'd1, 32'(csr_en));
        flush = 1'b1; rf_req = 1'b1; csr_req = 1'b1; #1;
        expect_now("flush_both_int", 32'd0, 32'(int_en));
        expect_now("flush_both_csr", 32'd0, 32'(csr_en));
        flush = 1'b0; #1;
        expect_now("unflush_int", 32'd1, 32'(int_en));
        expect_now("unflush_csr", 32'd1, 32'(csr_en));

        // Release reset, flush high without requests: flush_q follows.
        flush = 1'b1; rf_req = 1'b0; csr_req = 1'b0; rst_n = 1'b1;
        tick(1);
        expect_now("rel_flush_q", 32'd1, 32'(flush_q));
        chk_counters("idle_flush", 0, 0, 0);
        flush = 1'b0;
        tick(1);
        expect_now("flush_q_low", 32'd0, 32'(flush_q));

        // Reset beats a high flush on the flush register.
        rst_n = 1'b0; flush = 1'b1;
        tick(1);
        expect_now("rst_beats_flush_q", 32'd0, 32'(flush_q));
        rst_n = 1'b1;

        // Three squashed cycles with both requests: one count each.
        flush = 1'b1; rf_req = 1'b1; csr_req = 1'b1;
        tick(3);
        chk_counters("squash3", 0, 0, 3);

        // Commit both for 7 cycles, then integer only until saturation.
        flush = 1'b0;
        tick(7);
        chk_counters("commit7", 7, 7, 3);
        csr_req = 1'b0;
        tick(13);
        chk_counters("rf_sat", 15, 7, 3);
        tick(2);
        chk_counters("rf_sat_hold", 15, 7, 3);

        // Single request under flush still counts one squash.
        flush = 1'b1;
        tick(1);
        chk_counters("squash_rf_only", 15, 7, 4);

        // Mid-count reset with increment conditions true.
        rst_n = 1'b0; flush = 1'b0; rf_req = 1'b1; csr_req = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(7);
        chk_counters("recount7", 7, 7, 0);
        rst_n = 1'b0;
        tick(1);
        chk_counters("mid_rst", 0, 0, 0);
        expect_now("mid_rst_int_en", 32'd1, 32'(int_en));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
